// File: rtl/itlb_buffer.sv
// Single-entry instruction micro-TLB: translates unmapped segments directly and checks
// mapped fetches against one buffered TLB entry, refilling it from TLB search port 0 on a miss.

package itlb_buffer_pkg;
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [19:0] pfn1;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_entry_t;
endpackage

module itlb_buffer
  import itlb_buffer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  input  logic [7:0]  cp0_asid,
  input  logic [2:0]  cp0_k0,
  input  logic        tlb_flush,
  output logic [18:0] o_vpn2,
  input  logic        s0_found,
  input  tlb_entry_t  i_tlbentry,
  output logic        o_ready,
  output logic        o_stall,
  output logic [31:0] o_paddr,
  output logic        o_cacheable,
  output logic        o_exc_refill,
  output logic        o_exc_invalid
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOOKUP = 1'b1
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [18:0] lkp_vpn2_r;
  logic [7:0]  lkp_asid_r;
  logic        valid_r, found_r, g_r, v0_r, v1_r;
  logic [18:0] vpn2_r;
  logic [7:0]  asid_r;
  logic [19:0] pfn0_r, pfn1_r;
  logic [2:0]  c0_r, c1_r;

  logic        unmapped_s, hit_s, lkp_load_s;
  logic        ready_s, refill_s, invalid_s, cacheable_s;
  logic [31:0] paddr_s;
  logic [19:0] sel_pfn_s;
  logic [2:0]  sel_c_s;
  logic        sel_v_s;
  logic        unused_entry_s;

  assign unmapped_s = (i_vaddr[31:30] == 2'b10);
  assign hit_s      = valid_r & (vpn2_r == i_vaddr[31:13]) & (g_r | (asid_r == cp0_asid));
  assign sel_pfn_s  = i_vaddr[12] ? pfn1_r : pfn0_r;
  assign sel_c_s    = i_vaddr[12] ? c1_r : c0_r;
  assign sel_v_s    = i_vaddr[12] ? v1_r : v0_r;

  // The buffered tag comes from the lookup VPN2, so a not-found fill still hits and reports refill.
  assign unused_entry_s = ^{i_tlbentry.vpn2, i_tlbentry.asid, i_tlbentry.d0, i_tlbentry.d1};

  // Segment decode, buffer hit evaluation and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    lkp_load_s  = 1'b0;
    ready_s     = 1'b0;
    refill_s    = 1'b0;
    invalid_s   = 1'b0;
    paddr_s     = 32'h0000_0000;
    cacheable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req) begin
          if (unmapped_s) begin
            ready_s     = 1'b1;
            paddr_s     = {3'b000, i_vaddr[28:0]};
            cacheable_s = ~i_vaddr[29] & (cp0_k0 == 3'd3);
          end else if (hit_s) begin
            ready_s = 1'b1;
            if (!found_r) begin
              refill_s = 1'b1;
            end else if (!sel_v_s) begin
              invalid_s = 1'b1;
            end else begin
              paddr_s     = {sel_pfn_s, i_vaddr[11:0]};
              cacheable_s = (sel_c_s == 3'd3);
            end
          end else begin
            lkp_load_s  = 1'b1;
            state_nxt_s = ST_LOOKUP;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state and lookup key registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lkp_vpn2_r <= 19'd0;
      lkp_asid_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (lkp_load_s) begin
        lkp_vpn2_r <= i_vaddr[31:13];
        lkp_asid_r <= cp0_asid;
      end
    end
  end

  // Buffered entry: flush wins over the LOOKUP-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      found_r <= 1'b0;
      vpn2_r  <= 19'd0;
      asid_r  <= 8'd0;
      g_r     <= 1'b0;
      pfn0_r  <= 20'd0;
      pfn1_r  <= 20'd0;
      c0_r    <= 3'd0;
      c1_r    <= 3'd0;
      v0_r    <= 1'b0;
      v1_r    <= 1'b0;
    end else if (tlb_flush) begin
      valid_r <= 1'b0;
    end else if (state_r == ST_LOOKUP) begin
      valid_r <= 1'b1;
      found_r <= s0_found;
      vpn2_r  <= lkp_vpn2_r;
      asid_r  <= lkp_asid_r;
      g_r     <= i_tlbentry.g;
      pfn0_r  <= i_tlbentry.pfn0;
      pfn1_r  <= i_tlbentry.pfn1;
      c0_r    <= i_tlbentry.c0;
      c1_r    <= i_tlbentry.c1;
      v0_r    <= i_tlbentry.v0;
      v1_r    <= i_tlbentry.v1;
    end
  end

  assign o_vpn2        = lkp_vpn2_r;
  assign o_ready       = ready_s;
  assign o_stall       = i_req & ~ready_s;
  assign o_paddr       = paddr_s;
  assign o_cacheable   = cacheable_s;
  assign o_exc_refill  = refill_s;
  assign o_exc_invalid = invalid_s;

endmodule
